// File: rtl/alu_result_commit.sv
// alu_result_commit
//   Execution-stage consumer of ALU results. A one-entry holding register
//   captures each ALU result together with its decode side-band on a
//   valid/ready handshake. The entry resolves branches and jumps from the ALU
//   compare flags and then commits the op. A commit writes the register file
//   (the write port is shared with the LSU, and the LSU has priority),
//   updates the fetch PC and flushes younger ops when the op redirects.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      handshake for one ALU result + side-band
//   in_alu_dout              ALU result (jalr: rs1+imm)
//   in_alu_comp              compare flags {ltu, lt, eq}
//   in_pc, in_imm            op PC and sign-extended branch/jal offset
//   in_br_type               0 none,1 beq,2 bne,3 blt,4 bge,5 bltu,6 bgeu,
//                            7 jal,8 jalr, 9-15 none
//   in_rd_en, in_rd_addr     destination register write request
//   lsu_wb_valid             LSU owns the RF write port this cycle
//   rf_wr_en/addr/data       register-file write port
//   pc_wr_en, pc_next        fetch PC update
//   flush                    taken branch/jump, kill younger ops
//   misalign_trap            redirect target has bit 1 set
module alu_result_commit #(
  parameter int data_width     = 32,
  parameter int pc_width       = 32,
  parameter int reg_addr_width = 5,
  parameter int alu_comp_width = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_width-1:0]     in_alu_dout,
  input  logic [alu_comp_width-1:0] in_alu_comp,
  input  logic [pc_width-1:0]       in_pc,
  input  logic [pc_width-1:0]       in_imm,
  input  logic [3:0]                in_br_type,
  input  logic                      in_rd_en,
  input  logic [reg_addr_width-1:0] in_rd_addr,
  input  logic                      lsu_wb_valid,
  output logic                      rf_wr_en,
  output logic [reg_addr_width-1:0] rf_wr_addr,
  output logic [data_width-1:0]     rf_wr_data,
  output logic                      pc_wr_en,
  output logic [pc_width-1:0]       pc_next,
  output logic                      flush,
  output logic                      misalign_trap
);

  // Bit positions of the compare flags inside in_alu_comp.
  localparam int alu_comp_eq  = 0;
  localparam int alu_comp_lt  = 1;
  localparam int alu_comp_ltu = 2;

  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLT  = 4'd3;
  localparam logic [3:0] BR_BGE  = 4'd4;
  localparam logic [3:0] BR_BLTU = 4'd5;
  localparam logic [3:0] BR_BGEU = 4'd6;
  localparam logic [3:0] BR_JAL  = 4'd7;
  localparam logic [3:0] BR_JALR = 4'd8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Held entry
  logic [data_width-1:0]     r_alu_dout;
  logic [alu_comp_width-1:0] r_alu_comp;
  logic [pc_width-1:0]       r_pc;
  logic [pc_width-1:0]       r_imm;
  logic [3:0]                r_br_type;
  logic                      r_rd_en;
  logic [reg_addr_width-1:0] r_rd_addr;

  logic                w_full;
  logic                w_rd_write_needed;
  logic                w_blocked;
  logic                w_commit;
  logic                w_accept;
  logic                w_taken;
  logic                w_is_jump;
  logic                w_trap;
  logic [pc_width-1:0] w_pc_plus4;
  logic [pc_width-1:0] w_branch_target;
  logic [pc_width-1:0] w_jalr_target;
  logic [pc_width-1:0] w_target;

  // State register and entry capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_alu_dout <= '0;
      r_alu_comp <= '0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_br_type  <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_alu_dout <= in_alu_dout;
        r_alu_comp <= in_alu_comp;
        r_pc       <= in_pc;
        r_imm      <= in_imm;
        r_br_type  <= in_br_type;
        r_rd_en    <= in_rd_en;
        r_rd_addr  <= in_rd_addr;
      end
    end
  end

  // Branch resolution from the held entry
  always_comb begin
    w_taken   = 1'b0;
    w_is_jump = 1'b0;
    case (r_br_type)
      BR_BEQ:  w_taken =  r_alu_comp[alu_comp_eq];
      BR_BNE:  w_taken = !r_alu_comp[alu_comp_eq];
      BR_BLT:  w_taken =  r_alu_comp[alu_comp_lt];
      BR_BGE:  w_taken = !r_alu_comp[alu_comp_lt];
      BR_BLTU: w_taken =  r_alu_comp[alu_comp_ltu];
      BR_BGEU: w_taken = !r_alu_comp[alu_comp_ltu];
      BR_JAL, BR_JALR: begin
        w_taken   = 1'b1;
        w_is_jump = 1'b1;
      end
      default: w_taken = 1'b0;
    endcase

    w_pc_plus4       = r_pc + pc_width'(4);
    w_branch_target  = r_pc + r_imm;
    w_jalr_target    = pc_width'(r_alu_dout);
    w_jalr_target[0] = 1'b0;
    w_target         = (r_br_type == BR_JALR) ? w_jalr_target : w_branch_target;
    w_trap           = w_taken & w_target[1];
  end

  // Next state and commit outputs
  always_comb begin
    w_state_next  = r_state;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = '0;
    rf_wr_data    = '0;
    pc_wr_en      = 1'b0;
    pc_next       = '0;
    flush         = 1'b0;
    misalign_trap = 1'b0;

    w_full            = (r_state == ST_FULL);
    w_rd_write_needed = r_rd_en & (r_rd_addr != '0);
    w_blocked         = w_full & w_rd_write_needed & lsu_wb_valid;
    // A reset in the same cycle discards the entry without side effects.
    w_commit          = w_full & !w_blocked & !rst;

    if (w_commit) begin
      flush         = w_taken;
      misalign_trap = w_trap;
      pc_wr_en      = !w_trap;
      pc_next       = w_taken ? w_target : w_pc_plus4;
      rf_wr_en      = w_rd_write_needed & !w_trap;
      rf_wr_addr    = r_rd_addr;
      rf_wr_data    = w_is_jump ? data_width'(w_pc_plus4) : r_alu_dout;
    end

    // A redirecting commit refuses the next (wrong-path) op.
    in_ready = !w_full | (w_commit & !w_taken);
    w_accept = in_valid & in_ready;

    if (w_accept) begin
      w_state_next = ST_FULL;
    end else if (w_commit) begin
      w_state_next = ST_EMPTY;
    end
  end

endmodule
